conv_result_writer: RTL and testbench
=====================================

Name: conv_result_writer

Overview:
- Consumer end of the 3x3 convolution pixel stream.
- The pixel address generator issues 9 addresses per window, row-major over a 32x32 image: taps 0..8 = base+0,1,2,32,33,34,64,65,66. The image memory returns one pixel per address.
- This block does three things:
  - multiplies each returned pixel by its kernel tap and accumulates the 9 products;
  - applies shift, ReLU and unsigned saturation;
  - writes one result per window into the 30x30 result memory at sequential addresses 0..899, then flags done.

Parameters:
- PIX_W, 8, unsigned pixel width.
- WGT_W, 8, signed weight width.
- ACC_W, 21, signed accumulator width. PIX_W+WGT_W+1 covers one product; +4 guard bits cover 9 products.
- OUT_W, 8, unsigned result width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1).
- NUM_WIN, 900, windows per frame (30x30).
- RES_ADDR_W, 10, result address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame enable; the same signal that drives the pixel address generator. Low = pause.
- kernel  in  9*WGT_W  signed weights; tap k occupies bits [k*WGT_W +: WGT_W]. Must be static while start=1.
- pix_valid  in  1  pixel return strobe from image memory (one-cycle read latency)
- pix_data  in  PIX_W  returned pixel, unsigned
- res_wr_en  out  1  one-cycle write strobe to result memory
- res_addr  out  RES_ADDR_W  result write address
- res_data  out  OUT_W  result write data
- busy  out  1  high in ACCUM
- done  out  1  high in DONE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; tap=0; acc=0; win_cnt=0.
  - Outputs: res_wr_en=0, res_addr=0, res_data=0, busy=0, done=0.
- States: IDLE, ACCUM, DONE.
  - IDLE -> ACCUM when start=1. Clears tap, acc, win_cnt.
  - ACCUM -> DONE on the clock edge that issues the write for window NUM_WIN-1.
  - DONE -> IDLE when start=0. Pixels arriving in DONE or IDLE are ignored.
- ACCUM pixel acceptance:
  - Each pix_valid=1 accepts one pixel: acc += $unsigned(pix_data) * $signed(kernel[tap]), evaluated at full ACC_W signed width. Then tap increments.
  - At tap=0 the accumulator is loaded, not added: acc = product. This allows back-to-back windows with no idle cycle.
  - tap=8 accepted: tap->0; final sum captured into the result path.
- Result path:
  - Latency is 1 cycle. The cycle after the 9th pixel is accepted: res_wr_en=1, res_addr=win_cnt, res_data=sat(relu(final_sum >>> SHIFT)).
  - relu: negative -> 0. sat: values > 2^OUT_W-1 -> 2^OUT_W-1.
  - win_cnt increments on the write edge.
  - res_addr and res_data hold their last values while res_wr_en=0.
  - The write must not stall accumulation. The next window's tap-0 pixel can be accepted in the same cycle as the write.
- No backpressure on the result memory: it accepts every strobe.
- start=0 while in ACCUM is a pause, matching the address generator:
  - tap, acc and win_cnt hold.
  - A pixel arriving with pix_valid=1 is still accepted, because the read was issued before the pause.
  - The pending write still issues.
- win_cnt wraps never. The write of window NUM_WIN-1 (res_addr=899) moves the state to DONE. done rises the cycle after that write and holds until start=0.
- pix_valid for a 10th pixel with tap=0 in ACCUM starts the next window. The block tracks tap position only by count; no address checking.
- Reset mid-window: all state is lost; no partial write is issued.
- Arithmetic: the product is PIX_W+WGT_W+1 bits signed. Accumulation never overflows with the default ACC_W (max |sum| = 9*255*128 = 293760 < 2^20).

Decomposition:
- Shared package:
  - IMG_DIM=32, OUT_DIM=30, NUM_WIN=900, KSIZE=9;
  - PIX_W, WGT_W, ACC_W, OUT_W;
  - state encoding IDLE/ACCUM/DONE.
  - Shared with the pixel address generator, which uses the same IMG_DIM and KSIZE.
- One sub-module, conv_mac9: tap counter, tap weight select, multiply and load/accumulate. Output is sum_valid plus the final sum.
- The top level holds the FSM, win_cnt, relu/saturate and the write register.

Test Plan:
1. All weights=1, SHIFT=0, start=1, 9 pixels of value 10 with pix_valid=1 -> one cycle later res_wr_en=1, res_addr=0, res_data=90. busy=1 throughout.
2. Weights all -1, pixels 50 -> res_data=0 (ReLU). Weights all 127, pixels 255 -> sum 291465, res_data=255 (saturate). SHIFT=4 with sum 90 -> res_data=5.
3. Back-to-back windows: 18 consecutive pix_valid pulses with pixel=k (1..18), weights=1 -> writes (addr0,45) then (addr1,126). No gap cycle; acc reloads at tap 0.
4. Full frame: 8100 pixels (value 1, weights=1) -> exactly 900 writes, data=9, addresses 0..899 in order. done=1 the cycle after the addr 899 write. Extra pix_valid produces no write. start=0 -> done=0, state IDLE.
5. Pause: drop start after 4 pixels, hold 5 cycles with one late pix_valid (pixel accepted), resume for the remaining 4 -> single write with the correct 9-term sum. No spurious res_wr_en.
6. Assert reset after 5 pixels of window 3 -> all outputs 0 immediately (async). After release + start, the next write is at res_addr=0.

Source files
------------

// File: rtl/conv_result_writer_pkg.sv
// Shared constants and state encoding for the 3x3 convolution datapath.
// Also used by the pixel address generator (IMG_DIM, KSIZE).
package conv_result_writer_pkg;

    localparam int IMG_DIM    = 32;
    localparam int OUT_DIM    = IMG_DIM - 2;
    localparam int NUM_WIN    = OUT_DIM * OUT_DIM;
    localparam int KSIZE      = 9;
    localparam int PIX_W      = 8;
    localparam int WGT_W      = 8;
    localparam int ACC_W      = PIX_W + WGT_W + 1 + 4;
    localparam int OUT_W      = 8;
    localparam int RES_ADDR_W = $clog2(NUM_WIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_result_writer_if.sv
// Pixel return stream in, result memory write port out.
// slave = result writer side, master = memory/environment side.
interface conv_result_writer_if #(
    parameter int PIX_W      = conv_result_writer_pkg::PIX_W,
    parameter int OUT_W      = conv_result_writer_pkg::OUT_W,
    parameter int RES_ADDR_W = conv_result_writer_pkg::RES_ADDR_W
);

    logic                  pix_valid;
    logic [PIX_W-1:0]      pix_data;
    logic                  res_wr_en;
    logic [RES_ADDR_W-1:0] res_addr;
    logic [OUT_W-1:0]      res_data;

    modport slave (
        input  pix_valid,
        input  pix_data,
        output res_wr_en,
        output res_addr,
        output res_data
    );

    modport master (
        output pix_valid,
        output pix_data,
        input  res_wr_en,
        input  res_addr,
        input  res_data
    );

endinterface

// File: rtl/conv_mac9.sv
// Nine-tap multiply/accumulate: tap counter, weight select, load/accumulate.
// sum/sum_valid are combinational so the caller can register the result.
module conv_mac9 #(
    parameter int PIX_W = conv_result_writer_pkg::PIX_W,
    parameter int WGT_W = conv_result_writer_pkg::WGT_W,
    parameter int ACC_W = conv_result_writer_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [conv_result_writer_pkg::KSIZE*WGT_W-1:0] kernel,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    sum_valid,
    output logic signed [ACC_W-1:0] sum
);
    import conv_result_writer_pkg::*;

    logic [3:0]              tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] px_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [WGT_W-1:0] w;
    logic                    accept;
    logic                    last;

    assign w      = kernel[tap*WGT_W +: WGT_W];
    assign px_ext = ACC_W'({1'b0, pix_data});
    assign w_ext  = ACC_W'(w);
    assign prod   = px_ext * w_ext;
    assign accept = en & pix_valid;
    assign last   = (tap == 4'(KSIZE - 1));

    // Tap 0 loads rather than adds so windows can run back to back.
    assign sum       = (tap == '0) ? prod : acc + prod;
    assign sum_valid = accept & last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap <= '0;
            acc <= '0;
        end else if (clr) begin
            tap <= '0;
            acc <= '0;
        end else if (accept) begin
            acc <= sum;
            tap <= last ? '0 : tap + 4'd1;
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Convolution result writer: MAC, shift/ReLU/saturate, result memory writes.
// One write per window to sequential addresses, then holds done until start drops.
module conv_result_writer #(
    parameter int PIX_W      = conv_result_writer_pkg::PIX_W,
    parameter int WGT_W      = conv_result_writer_pkg::WGT_W,
    parameter int ACC_W      = conv_result_writer_pkg::ACC_W,
    parameter int OUT_W      = conv_result_writer_pkg::OUT_W,
    parameter int SHIFT      = 0,
    parameter int NUM_WIN    = conv_result_writer_pkg::NUM_WIN,
    parameter int RES_ADDR_W = conv_result_writer_pkg::RES_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [conv_result_writer_pkg::KSIZE*WGT_W-1:0] kernel,
    conv_result_writer_if.slave bus,
    output logic busy,
    output logic done
);
    import conv_result_writer_pkg::*;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

    state_t                  state;
    state_t                  state_n;
    logic                    sum_valid;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        res_next;
    logic [RES_ADDR_W-1:0]   win_cnt;
    logic                    frame_go;
    logic                    last_wr;

    assign frame_go = (state == S_IDLE) && start;
    assign last_wr  = bus.res_wr_en
                   && (win_cnt == RES_ADDR_W'(NUM_WIN - 1));

    conv_mac9 #(
        .PIX_W (PIX_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .en        (state == S_ACCUM),
        .clr       (frame_go),
        .kernel    (kernel),
        .pix_valid (bus.pix_valid),
        .pix_data  (bus.pix_data),
        .sum_valid (sum_valid),
        .sum       (sum)
    );

    assign shifted = sum >>> SHIFT;

    always_comb begin
        res_next = '0;
        unique case (1'b1)
            shifted[ACC_W-1]:    res_next = '0;
            (shifted > SAT_MAX): res_next = '1;
            default:             res_next = shifted[OUT_W-1:0];
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start)   state_n = S_ACCUM;
            S_ACCUM: if (last_wr) state_n = S_DONE;
            S_DONE:  if (!start)  state_n = S_IDLE;
            default:              state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.res_wr_en <= 1'b0;
            bus.res_addr  <= '0;
            bus.res_data  <= '0;
        end else begin
            bus.res_wr_en <= sum_valid;
            if (sum_valid) begin
                bus.res_addr <= win_cnt;
                bus.res_data <= res_next;
            end
        end
    end

    // Advances as each strobe retires, well before the next window completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             win_cnt <= '0;
        else if (frame_go)      win_cnt <= '0;
        else if (bus.res_wr_en) win_cnt <= win_cnt + 1'b1;
    end

    assign busy = (state == S_ACCUM);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: SHIFT=0 and SHIFT=4 instances share stimulus,
// checked each cycle against a window/queue reference model.
module tb_conv_result_writer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [71:0] kernel;
    logic        pv;
    logic [7:0]  pd;
    logic        busy0, done0, busy4, done4;

    conv_result_writer_if if0 ();
    conv_result_writer_if if4 ();

    assign if0.pix_valid = pv;
    assign if0.pix_data  = pd;
    assign if4.pix_valid = pv;
    assign if4.pix_data  = pd;

    conv_result_writer #(.SHIFT(0)) u0 (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kernel (kernel),
        .bus    (if0.slave),
        .busy   (busy0),
        .done   (done0)
    );

    conv_result_writer #(.SHIFT(4)) u4 (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kernel (kernel),
        .bus    (if4.slave),
        .busy   (busy4),
        .done   (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_seen = 0;

    // reference model: 0 idle, 1 running, 2 done
    int  m_mode;
    int  q[$];
    int  wins;
    int  wt[9];
    bit  m_wr;
    int  m_addr, m_d0, m_d4;

    typedef struct {
        int w;
        int p;
        int d0;
        int d4;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s actual=%0d required=%0d t=%0t",
                         nm, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int s);
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        q.delete();
        wins   = 0;
        m_wr   = 0;
        m_addr = 0;
        m_d0   = 0;
        m_d4   = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input int d);
        bit nw;
        nw = 0;
        case (m_mode)
            0: if (s) begin
                m_mode = 1;
                q.delete();
                wins = 0;
            end
            1: begin
                if (m_wr && m_addr == 899) m_mode = 2;
                if (v) begin
                    q.push_back(d);
                    if (q.size() == 9) begin
                        int a;
                        a = 0;
                        for (int i = 0; i < 9; i++) a += q[i] * wt[i];
                        m_addr = wins;
                        wins++;
                        m_d0 = clampv(a);
                        m_d4 = clampv(a >>> 4);
                        nw = 1;
                        q.delete();
                    end
                end
            end
            default: if (!s) m_mode = 0;
        endcase
        m_wr = nw;
    endtask

    task automatic check_cycle();
        if (if0.res_wr_en) wr_seen++;
        chk("busy",     busy0, int'(m_mode == 1));
        chk("done",     done0, int'(m_mode == 2));
        chk("busy_s4",  busy4, int'(m_mode == 1));
        chk("done_s4",  done4, int'(m_mode == 2));
        chk("wr_en",    if0.res_wr_en, m_wr);
        chk("wr_en_s4", if4.res_wr_en, m_wr);
        chk("addr",     if0.res_addr, m_addr);
        chk("data",     if0.res_data, m_d0);
        chk("data_s4",  if4.res_data, m_d4);
    endtask

    task automatic step(input bit s, input bit v, input int d);
        start = s;
        pv    = v;
        pd    = 8'(d);
        @(posedge clk);
        model_edge(s, v, d);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_uniform(input int v);
        for (int k = 0; k < 9; k++) begin
            wt[k] = v;
            kernel[k*8 +: 8] = 8'(v);
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < 9; k++) begin
            wt[k] = int'($urandom_range(0, 255)) - 128;
            kernel[k*8 +: 8] = 8'(wt[k]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        pv    = 1'b0;
        pd    = '0;
        model_reset();
        #1;
        check_cycle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        reset  = 1'b0;
        start  = 1'b0;
        pv     = 1'b0;
        pd     = '0;
        kernel = '0;
        for (int k = 0; k < 9; k++) wt[k] = 0;
        model_reset();

        tbl[0] = '{1,    10,  90,  5};
        tbl[1] = '{-1,   50,  0,   0};
        tbl[2] = '{127,  255, 255, 255};
        tbl[3] = '{2,    7,   126, 7};
        tbl[4] = '{1,    255, 255, 143};
        tbl[5] = '{0,    200, 0,   0};
        tbl[6] = '{-128, 1,   0,   0};
        tbl[7] = '{3,    9,   243, 15};
        tbl[8] = '{4,    8,   255, 18};

        @(negedge clk);
        do_reset();

        // single windows, uniform weights/pixels
        foreach (tbl[i]) begin
            do_reset();
            set_uniform(tbl[i].w);
            step(1, 0, 0);
            for (int j = 0; j < 9; j++) step(1, 1, tbl[i].p);
            chk("tbl_wr",   if0.res_wr_en, 1);
            chk("tbl_addr", if0.res_addr, 0);
            chk("tbl_d0",   if0.res_data, tbl[i].d0);
            chk("tbl_d4",   if4.res_data, tbl[i].d4);
            step(1, 0, 0);
        end

        // back-to-back windows, pixel = 1..18
        do_reset();
        set_uniform(1);
        step(1, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            step(1, 1, k);
            if (k == 9) begin
                chk("b2b_addr0", if0.res_addr, 0);
                chk("b2b_data0", if0.res_data, 45);
            end
            if (k == 18) begin
                chk("b2b_wr1",   if0.res_wr_en, 1);
                chk("b2b_addr1", if0.res_addr, 1);
                chk("b2b_data1", if0.res_data, 126);
            end
        end
        step(1, 0, 0);

        // pause mid-window with one late pixel
        do_reset();
        set_random();
        step(1, 0, 0);
        base = wr_seen;
        for (int k = 0; k < 4; k++) step(1, 1, 20 + k);
        for (int k = 0; k < 5; k++) step(0, k == 2, 77);
        for (int k = 0; k < 4; k++) step(1, 1, 200 + k);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("pause_writes", wr_seen - base, 1);

        // reset during window 3
        do_reset();
        set_uniform(2);
        step(1, 0, 0);
        for (int k = 0; k < 23; k++) step(1, 1, 30 + k);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_wr",   if0.res_wr_en, 0);
        chk("rst_addr", if0.res_addr, 0);
        chk("rst_data", if0.res_data, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0);
        for (int k = 0; k < 9; k++) step(1, 1, 3);
        chk("rst_next_addr", if0.res_addr, 0);
        chk("rst_next_data", if0.res_data, 54);

        // full frame
        do_reset();
        set_uniform(1);
        step(1, 0, 0);
        base = wr_seen;
        for (int k = 0; k < 8100; k++) step(1, 1, 1);
        chk("frame_last_addr", if0.res_addr, 899);
        chk("frame_writes", wr_seen - base, 900);
        step(1, 1, 1);
        chk("frame_done", done0, 1);
        for (int k = 0; k < 12; k++) step(1, 1, 1);
        chk("frame_extra", wr_seen - base, 900);
        step(0, 0, 0);
        chk("frame_idle_done", done0, 0);
        chk("frame_idle_busy", busy0, 0);

        // randomized traffic with pauses
        for (int r = 0; r < 4; r++) begin
            do_reset();
            set_random();
            step(1, 0, 0);
            for (int c = 0; c < 300; c++)
                step(($urandom % 8) != 0, ($urandom % 4) != 0,
                     int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
